// File: rtl/countdown_timer.sv
// Loadable modulo down-counter: counts a programmable reload value R down to 0
// (R+1 cycles per period), strobes terminal at 0, then auto-reloads or stops.
module countdown_timer #(
  parameter int N              = 8,
  parameter int DEFAULT_RELOAD = 159
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         start,
  input  logic         stop,
  input  logic         auto_reload,
  input  logic         load,
  input  logic [N-1:0] load_value,
  output logic [N-1:0] count,
  output logic         busy,
  output logic         terminal,
  output logic         expired
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [N-1:0] RESET_RELOAD = N'(DEFAULT_RELOAD);

  state_t       state, state_next;
  logic [N-1:0] reload_reg;
  logic [N-1:0] count_next;
  logic [N-1:0] start_value;
  logic         expired_next;

  // A load in the same cycle as a start takes effect immediately.
  assign start_value = load ? load_value : reload_reg;

  assign busy     = (state == RUN);
  assign terminal = (state == RUN) && en && (count == '0) && !stop && !start;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned; that is what keeps this block free of inferred latches.
    state_next   = state;
    count_next   = count;
    expired_next = expired;

    unique case (state)
      IDLE: begin
        if (start) begin
          state_next   = RUN;
          count_next   = start_value;
          expired_next = 1'b0;
        end
      end
      RUN: begin
        if (stop) begin
          state_next = IDLE;
        end else if (start) begin
          count_next = start_value;
        end else if (terminal) begin
          if (auto_reload) begin
            count_next = reload_reg;
          end else begin
            state_next   = IDLE;
            expired_next = 1'b1;
          end
        end else if (en) begin
          count_next = count - N'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: reset is sampled on the clock edge (synchronous), and all state uses
  // non-blocking assignments so every register updates from pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      count      <= '0;
      expired    <= 1'b0;
      reload_reg <= RESET_RELOAD;
    end else begin
      state   <= state_next;
      count   <= count_next;
      expired <= expired_next;
      if (load) reload_reg <= load_value;
    end
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: a behavioural model pushes expected
// results into a scoreboard queue as stimulus is driven; outputs are popped and compared.
module tb_countdown_timer;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         en;
  logic         start;
  logic         stop;
  logic         auto_reload;
  logic         load;
  logic [N-1:0] load_value;
  logic [N-1:0] count;
  logic         busy;
  logic         terminal;
  logic         expired;

  countdown_timer #(.N(N), .DEFAULT_RELOAD(159)) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .start       (start),
    .stop        (stop),
    .auto_reload (auto_reload),
    .load        (load),
    .load_value  (load_value),
    .count       (count),
    .busy        (busy),
    .terminal    (terminal),
    .expired     (expired)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         term;
    logic [N-1:0] cnt;
    logic         busy;
    logic         expd;
  } exp_t;

  exp_t queue_exp[$];

  // Reference model state
  logic         m_busy;
  logic [N-1:0] m_count;
  logic [N-1:0] m_reload;
  logic         m_expired;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_term = 0;
  int term_gap  = 0;
  int term_cnt  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_step(output exp_t e);
    logic [N-1:0] sv;
    logic         t;
    t  = m_busy && en && (m_count == 0) && !stop && !start;
    sv = load ? load_value : m_reload;
    if (!reset) begin
      m_busy = 1'b0; m_count = '0; m_expired = 1'b0; m_reload = 8'd159;
    end else begin
      if (m_busy) begin
        if (stop)          m_busy = 1'b0;
        else if (start)    m_count = sv;
        else if (t) begin
          if (auto_reload) m_count = m_reload;
          else begin m_busy = 1'b0; m_expired = 1'b1; end
        end else if (en)   m_count = m_count - 8'd1;
      end else if (start) begin
        m_busy = 1'b1; m_count = sv; m_expired = 1'b0;
      end
      if (load) m_reload = load_value;
    end
    e.term = t; e.cnt = m_count; e.busy = m_busy; e.expd = m_expired;
  endtask

  // One clock: push expectation, sample terminal mid-cycle, sample state after edge.
  task automatic tick();
    exp_t e;
    logic obs_term;
    model_step(e);
    queue_exp.push_back(e);
    @(negedge clk);
    obs_term = terminal;
    @(posedge clk);
    #1;
    e = queue_exp.pop_front();
    check("terminal", obs_term, e.term);
    check("count",    count,    e.cnt);
    check("busy",     busy,     e.busy);
    check("expired",  expired,  e.expd);
    if (obs_term) begin
      term_gap  = cyc - last_term;
      last_term = cyc;
      term_cnt++;
    end
    cyc++;
  endtask

  task automatic idle_inputs();
    reset = 1'b1; en = 1'b1; start = 1'b0; stop = 1'b0;
    auto_reload = 1'b1; load = 1'b0; load_value = '0;
  endtask

  task automatic load_start(input logic [N-1:0] r, input logic ar);
    idle_inputs();
    auto_reload = ar; load = 1'b1; load_value = r; start = 1'b1;
    tick();
    idle_inputs();
    auto_reload = ar;
  endtask

  task automatic do_stop();
    idle_inputs();
    stop = 1'b1;
    tick();
    idle_inputs();
  endtask

  initial begin
    bit found;
    idle_inputs();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    m_busy = 1'b0; m_count = '0; m_expired = 1'b0; m_reload = 8'd159;
    tick();   // checked reset state
    check("reset_count", count, 0);
    check("reset_busy",  busy,  0);

    // Default reload, periodic: terminal once per 160 cycles
    idle_inputs();
    start = 1'b1;
    tick();
    check("start_count_default", count, 159);
    idle_inputs();
    term_cnt = 0;
    repeat (320) tick();
    check("default_term_cnt", term_cnt, 2);
    check("default_term_gap", term_gap, 160);
    do_stop();

    // One-shot R=3
    load_start(8'd3, 1'b0);
    term_cnt = 0;
    repeat (6) tick();
    check("oneshot_term_cnt", term_cnt, 1);
    check("oneshot_expired",  expired, 1);
    check("oneshot_busy",     busy, 0);
    check("oneshot_count",    count, 0);

    // R=5 periodic with a 4-cycle freeze at count 2
    load_start(8'd5, 1'b1);
    term_cnt = 0;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin tick(); found = (term_cnt >= 1); end
    check("bound_r5_first_term", found, 1);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin tick(); found = (m_count == 2); end
    check("bound_r5_count2", found, 1);
    en = 1'b0;
    repeat (4) tick();
    check("frozen_count", count, 2);
    en = 1'b1;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin tick(); found = (term_cnt >= 2); end
    check("bound_r5_second_term", found, 1);
    check("freeze_term_gap", term_gap, 10);

    // R=9: stop at count 0, then retrigger at count 4
    load_start(8'd9, 1'b1);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin tick(); found = (m_count == 0); end
    check("bound_r9_zero", found, 1);
    term_cnt = 0;
    do_stop();
    check("stop_no_term", term_cnt, 0);
    check("stop_busy",    busy, 0);
    check("stop_expired", expired, 0);
    start = 1'b1;
    tick();
    idle_inputs();
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin tick(); found = (m_count == 4); end
    check("bound_r9_four", found, 1);
    start = 1'b1;
    tick();
    check("retrigger_count", count, 9);
    idle_inputs();
    tick();
    do_stop();

    // R=0 periodic: terminal every cycle
    load_start(8'd0, 1'b1);
    term_cnt = 0;
    repeat (5) tick();
    check("r0_periodic_terms", term_cnt, 5);
    do_stop();

    // R=0 one-shot: single pulse then idle
    load_start(8'd0, 1'b0);
    term_cnt = 0;
    repeat (3) tick();
    check("r0_oneshot_terms", term_cnt, 1);
    check("r0_oneshot_busy", busy, 0);

    // Reset mid-run at count 7 with start and stop asserted
    load_start(8'd12, 1'b1);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin tick(); found = (m_count == 7); end
    check("bound_r12_seven", found, 1);
    reset = 1'b0; start = 1'b1; stop = 1'b1;
    tick();
    check("midreset_count", count, 0);
    check("midreset_busy",  busy, 0);
    idle_inputs();
    tick();
    check("post_reset_terminal", terminal, 0);
    start = 1'b1;
    tick();
    check("post_reset_reload", count, 159);
    idle_inputs();
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
Loadable modulo down-counter: the count-down counterpart of the team's free-running up-counting modulo counter. It counts from a programmable reload value R down to 0, giving R+1 cycles per period. It pulses `terminal` on reaching 0, then either auto-reloads (periodic tick) or stops (one-shot). It is used as the timer or prescaler feeding the team's clock-enable and sequencing logic.

Parameters:
N  8  counter and reload width in bits
DEFAULT_RELOAD  159  reload value after reset; period = DEFAULT_RELOAD+1 cycles; must be < 2^N

Ports:
clk  input  1  single system clock; all state changes on the rising edge
reset  input  1  synchronous, active-low reset; sampled on the rising clk edge
en  input  1  count enable; low in RUN freezes count
start  input  1  start or retrigger request (level, sampled each cycle)
stop  input  1  abort request (level, sampled each cycle)
auto_reload  input  1  1 = periodic mode, 0 = one-shot mode; sampled when count reaches 0
load  input  1  write load_value into the reload register
load_value  input  N  new reload value
count  output  N  current count (registered)
busy  output  1  high while state = RUN
terminal  output  1  one-cycle strobe when the period completes
expired  output  1  sticky flag: one-shot run completed

Behaviour:
- Reset (reset==0 at posedge clk): reload_reg = DEFAULT_RELOAD, count = 0, state = IDLE, expired = 0. Reset overrides all other inputs, including mid-run.
- Reset outputs: busy = 0, terminal = 0.
- States:
  - IDLE: count holds its value.
  - RUN: counting.
- Register load: load=1 writes load_value into reload_reg in any state.
  - In RUN, the current count is unaffected; the new value applies at the next reload or start.
- Start in IDLE: next cycle state = RUN, count = reload value, expired cleared.
  - If load is high in the same cycle, count = load_value (the new value is used immediately).
- Start in RUN (retrigger): count = reload value (load_value if load is also high), state stays RUN, no terminal.
- Stop: if stop=1 in RUN, next state = IDLE.
  - count holds its current value, expired unchanged, terminal suppressed.
  - stop beats start and beats terminal in the same cycle.
  - stop in IDLE has no effect.
- Counting: in RUN with en=1, start=0, stop=0 and count>0, count decrements by 1 per cycle.
  - en=0 freezes count and suppresses terminal; state stays RUN.
- terminal (combinational from registered state) = (state==RUN) && en && (count==0) && !stop && !start.
  - High for exactly one cycle per period.
- At a cycle where terminal=1:
  - auto_reload=1: count = reload_reg next cycle, stay RUN.
  - auto_reload=0: state = IDLE, count stays 0, expired = 1.
- Period: from start at reload R with en held high, terminal is high in cycle R+1 after the start edge. Periodic terminal spacing = R+1 cycles.
- R = 0: count is 0 in every RUN cycle.
  - Periodic mode: terminal is high every cycle.
  - One-shot mode: a single terminal pulse, then IDLE.
- Wrap-around: count never underflows; 0 always reloads or idles. Arithmetic is unsigned, N bits.
- Expired flag: set only by one-shot completion; cleared only by start or reset; held across stop.

Test Plan:
- Reset then start with en=1, auto_reload=1, default R=159 -> count 159,158,…,0; terminal high once every 160 cycles; busy=1 throughout.
- load_value=3 with load, then start, auto_reload=0 -> count 3,2,1,0; one terminal pulse with count=0; next cycle busy=0, expired=1, count=0.
- R=5, periodic run, en low for 4 cycles at count=2 -> count frozen at 2, no terminal; resume; terminal spacing = 6+4 = 10 cycles for that period.
- R=9, periodic run, stop asserted at count=0 -> no terminal, busy=0 next cycle, count=0, expired=0. Separately, start at count=4 -> count=9 next cycle, no terminal.
- R=0 in periodic mode -> terminal high every RUN cycle. R=0 in one-shot mode -> a single pulse, then IDLE.
- Reset (reset=0) asserted mid-run at count=7 -> next cycle count=0, busy=0, terminal=0, expired=0, reload_reg=159; start and stop ignored while reset=0.
